// File: rtl/flt_evt_det_pkg.sv
// Shared defaults and types for the fault event detector.
package pwr_flt_pkg;

    localparam int FLT_CW_DEF   = 4;
    localparam int SYNC_STG_DEF = 2;

    typedef logic [FLT_CW_DEF-1:0] flt_cnt_t;

endpackage

// File: rtl/flt_evt_det_if.sv
// Filtered-fault status and rwc_reg logic-set strobe bus.
interface flt_evt_det_if #(
    parameter int DW = 8
);
    logic [DW-1:0] o_flt_sta;
    logic [DW-1:0] o_lgc_wen;
    logic [DW-1:0] o_lgc_wdata;

    modport master (output o_flt_sta, output o_lgc_wen, output o_lgc_wdata);
    modport slave  (input  o_flt_sta, input  o_lgc_wen, input  o_lgc_wdata);
endinterface

// File: rtl/flt_evt_det_chn.sv
// One fault channel: synchroniser, deglitch counter, filtered state and set strobe.
module flt_bit_chn #(
    parameter int FLT_CW   = 4,
    parameter int SYNC_STG = 2,
    parameter bit LEVEL    = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_raw,
    input  logic              i_en,
    input  logic [FLT_CW-1:0] i_thr,
    output logic              o_flt,
    output logic              o_wen
);

    logic [SYNC_STG-1:0] r_sync;
    logic [FLT_CW-1:0]   r_cnt;
    logic                r_flt;
    logic                r_wen;

    logic              w_s;
    logic [FLT_CW-1:0] w_lim;
    logic              w_flip;
    logic              w_flt_next;
    logic              w_set;

    // A threshold of 0 behaves as 1; ">=" lets a lowered threshold flip on the next mismatch.
    assign w_s        = r_sync[SYNC_STG-1];
    assign w_lim      = (i_thr == '0) ? '0 : (i_thr - FLT_CW'(1));
    assign w_flip     = (w_s != r_flt) && (r_cnt >= w_lim);
    assign w_flt_next = w_flip ? w_s : r_flt;
    assign w_set      = LEVEL ? w_flt_next : (w_flip & w_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_flt  <= 1'b0;
            r_wen  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_raw};
            if ((w_s == r_flt) || w_flip) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + FLT_CW'(1);
            end
            r_flt <= w_flt_next;
            r_wen <= w_set & i_en;
        end
    end

    assign o_flt = r_flt;
    assign o_wen = r_wen;

endmodule

// File: rtl/flt_evt_det.sv
// Fault event detector: DW filtered channels feeding rwc_reg logic-set strobes.
module flt_evt_det
    import pwr_flt_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            FLT_CW     = FLT_CW_DEF,
    parameter int            SYNC_STG   = SYNC_STG_DEF,
    parameter logic [DW-1:0] LEVEL_MASK = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DW-1:0]     i_raw_flt,
    input  logic [DW-1:0]     i_flt_en,
    input  logic [FLT_CW-1:0] i_flt_thr,
    flt_evt_det_if.master     evt_if
);

    logic [DW-1:0] w_sta;
    logic [DW-1:0] w_wen;

    for (genvar g = 0; g < DW; g++) begin : g_chn
        flt_bit_chn #(
            .FLT_CW   (FLT_CW),
            .SYNC_STG (SYNC_STG),
            .LEVEL    (LEVEL_MASK[g])
        ) u_chn (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_raw (i_raw_flt[g]),
            .i_en  (i_flt_en[g]),
            .i_thr (i_flt_thr),
            .o_flt (w_sta[g]),
            .o_wen (w_wen[g])
        );
    end

    // Set-only interface: data mirrors the strobe so rwc_reg can only ever set bits.
    assign evt_if.o_flt_sta   = w_sta;
    assign evt_if.o_lgc_wen   = w_wen;
    assign evt_if.o_lgc_wdata = w_wen;

endmodule
